// File: rtl/ddr3_rd_arbiter_if.sv
// Requester and DDR3 reader bundle for the two-port read arbiter.
// slave is the arbiter side; master is the requesters plus the reader.
interface ddr3_rd_arbiter_if;
  logic        req0;
  logic [22:0] addr0;
  logic [20:0] cnt0;
  logic        req1;
  logic [22:0] addr1;
  logic [20:0] cnt1;
  logic        gnt0;
  logic        gnt1;
  logic        done0;
  logic        done1;
  logic        err0;
  logic        err1;
  logic [22:0] ddr3_rd_start_addr;
  logic [20:0] ddr3_rd_burst_cnt;
  logic        enable_reading;
  logic        reading_done;
  logic        busy;

  modport slave (
    input  req0, addr0, cnt0,
    input  req1, addr1, cnt1,
    input  reading_done,
    output gnt0, gnt1,
    output done0, done1,
    output err0, err1,
    output ddr3_rd_start_addr,
    output ddr3_rd_burst_cnt,
    output enable_reading,
    output busy
  );

  modport master (
    output req0, addr0, cnt0,
    output req1, addr1, cnt1,
    output reading_done,
    input  gnt0, gnt1,
    input  done0, done1,
    input  err0, err1,
    input  ddr3_rd_start_addr,
    input  ddr3_rd_burst_cnt,
    input  enable_reading,
    input  busy
  );
endinterface

// File: rtl/ddr3_rd_arbiter.sv
// Round-robin arbiter sharing one DDR3 burst reader between two requesters,
// with a RUN+RELEASE watchdog that aborts a stalled transfer.
module ddr3_rd_arbiter #(
  parameter logic [23:0] TIMEOUT = 24'd10_000_000
) (
  input logic              clk,
  input logic              reset,
  ddr3_rd_arbiter_if.slave bus
);

  localparam int S_IDLE  = 0;
  localparam int S_GRANT = 1;
  localparam int S_RUN   = 2;
  localparam int S_REL   = 3;
  localparam int S_DONE  = 4;
  localparam int S_ABORT = 5;

  typedef enum logic [5:0] {
    IDLE    = 6'b000001,
    GRANT   = 6'b000010,
    RUN     = 6'b000100,
    RELEASE = 6'b001000,
    DONE    = 6'b010000,
    ABORT   = 6'b100000
  } state_e;

  state_e      state_q, state_d;
  logic        owner_q, owner_d;
  logic        last_q, last_d;
  logic [23:0] timer_q, timer_d, timer_inc;
  logic [22:0] addr_q, addr_d;
  logic [20:0] cnt_q, cnt_d;
  logic        sync1_q, done_s_q;
  logic        tmo;

  logic gnt0_q, gnt1_q, en_q, busy_q;
  logic done0_q, done1_q, err0_q, err1_q;
  logic gnt0_d, gnt1_d, en_d, busy_d;
  logic done0_d, done1_d, err0_d, err1_d;

  assign timer_inc = (timer_q == '1) ? timer_q : timer_q + 24'd1;
  assign tmo       = (timer_q >= TIMEOUT);

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    timer_d = timer_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    unique case (1'b1)
      state_q[S_IDLE]: begin
        if (bus.req0 || bus.req1) begin
          owner_d = (bus.req0 && bus.req1) ? ~last_q : bus.req1;
          addr_d  = owner_d ? bus.addr1 : bus.addr0;
          cnt_d   = owner_d ? bus.cnt1 : bus.cnt0;
          timer_d = '0;
          state_d = GRANT;
        end
      end
      state_q[S_GRANT]: begin
        timer_d = '0;
        state_d = (cnt_q == '0) ? DONE : RUN;
      end
      state_q[S_RUN]: begin
        timer_d = timer_inc;
        if (done_s_q)  state_d = RELEASE;
        else if (tmo)  state_d = ABORT;
      end
      state_q[S_REL]: begin
        timer_d = timer_inc;
        if (!done_s_q) state_d = DONE;
        else if (tmo)  state_d = ABORT;
      end
      state_q[S_DONE], state_q[S_ABORT]: begin
        last_d  = owner_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs are registered from the next state so they move on state entry.
  assign gnt0_d  = !state_d[S_IDLE] && !owner_d;
  assign gnt1_d  = !state_d[S_IDLE] &&  owner_d;
  assign en_d    = state_d[S_RUN];
  assign busy_d  = !state_d[S_IDLE];
  assign done0_d = state_d[S_DONE]  && !owner_d;
  assign done1_d = state_d[S_DONE]  &&  owner_d;
  assign err0_d  = state_d[S_ABORT] && !owner_d;
  assign err1_d  = state_d[S_ABORT] &&  owner_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      owner_q  <= 1'b0;
      last_q   <= 1'b1;
      timer_q  <= '0;
      addr_q   <= '0;
      cnt_q    <= '0;
      sync1_q  <= 1'b0;
      done_s_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      last_q   <= last_d;
      timer_q  <= timer_d;
      addr_q   <= addr_d;
      cnt_q    <= cnt_d;
      sync1_q  <= bus.reading_done;
      done_s_q <= sync1_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      gnt0_q  <= 1'b0;
      gnt1_q  <= 1'b0;
      en_q    <= 1'b0;
      busy_q  <= 1'b0;
      done0_q <= 1'b0;
      done1_q <= 1'b0;
      err0_q  <= 1'b0;
      err1_q  <= 1'b0;
    end else begin
      gnt0_q  <= gnt0_d;
      gnt1_q  <= gnt1_d;
      en_q    <= en_d;
      busy_q  <= busy_d;
      done0_q <= done0_d;
      done1_q <= done1_d;
      err0_q  <= err0_d;
      err1_q  <= err1_d;
    end
  end

  assign bus.gnt0               = gnt0_q;
  assign bus.gnt1               = gnt1_q;
  assign bus.enable_reading     = en_q;
  assign bus.busy               = busy_q;
  assign bus.done0              = done0_q;
  assign bus.done1              = done1_q;
  assign bus.err0               = err0_q;
  assign bus.err1               = err1_q;
  assign bus.ddr3_rd_start_addr = addr_q;
  assign bus.ddr3_rd_burst_cnt  = cnt_q;

endmodule

// File: tb/tb_ddr3_rd_arbiter.sv
// Transaction-level bench for ddr3_rd_arbiter: a reader model answers
// enable_reading and each transfer is scored against arbitration rules.
module tb_ddr3_rd_arbiter;

  localparam logic [23:0] TO = 24'd64;
  localparam int NORM  = 0;
  localparam int NEVER = 1;
  localparam int STUCK = 2;

  logic clk = 1'b0;
  logic reset;
  int   n_chk = 0;
  int   n_pass = 0;
  bit   last_own;

  ddr3_rd_arbiter_if bus();

  ddr3_rd_arbiter #(.TIMEOUT(TO)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
  endtask

  function automatic logic [31:0] outs();
    return {24'd0, bus.gnt0, bus.gnt1, bus.done0, bus.done1,
            bus.err0, bus.err1, bus.enable_reading, bus.busy};
  endfunction

  function automatic logic [22:0] ra();
    return 23'($urandom);
  endfunction

  function automatic logic [20:0] rc();
    return 21'($urandom_range(1, 2097151));
  endfunction

  task automatic do_reset();
    reset = 1'b1;
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
    bus.addr0 = '0;
    bus.addr1 = '0;
    bus.cnt0 = '0;
    bus.cnt1 = '0;
    bus.reading_done = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_out", outs(), 0);
    chk("reset_addr", 32'(bus.ddr3_rd_start_addr), 0);
    chk("reset_cnt", 32'(bus.ddr3_rd_burst_cnt), 0);
    reset = 1'b0;
    last_own = 1'b1;
  endtask

  task automatic txn(input bit r0, input bit r1,
                     input logic [22:0] a0, input logic [20:0] c0,
                     input logic [22:0] a1, input logic [20:0] c1,
                     input int mode, input int lat, input bit hold);
    bit own, exp_done, granted, g_who, fen;
    logic [22:0] ea, fa;
    logic [20:0] ec, fc;
    int cyc, g_cyc, en_first, en_n, fin, bad;
    int nd0, nd1, ne0, ne1;
    own      = (r0 && r1) ? ~last_own : r1;
    ea       = own ? a1 : a0;
    ec       = own ? c1 : c0;
    exp_done = (ec == '0) || (mode == NORM);
    bus.req0 = r0;
    bus.req1 = r1;
    bus.addr0 = a0;
    bus.cnt0 = c0;
    bus.addr1 = a1;
    bus.cnt1 = c1;
    bus.reading_done = 1'b0;
    granted = 0; g_who = 0; fen = 0;
    fa = '0; fc = '0;
    cyc = 0; g_cyc = 0; en_first = 0; en_n = 0; fin = -1; bad = 0;
    nd0 = 0; nd1 = 0; ne0 = 0; ne1 = 0;
    while (fin < 0 && cyc < 400) begin
      @(posedge clk);
      #1;
      cyc++;
      if (bus.gnt0 && bus.gnt1) bad++;
      if ((bus.done0 || bus.done1) && (bus.err0 || bus.err1)) bad++;
      if (!granted && (bus.gnt0 || bus.gnt1)) begin
        granted = 1;
        g_cyc = cyc;
        g_who = bus.gnt1;
      end
      if (granted && cyc == g_cyc + 1) begin
        bus.addr0 = ra();
        bus.addr1 = ra();
        bus.cnt0 = rc();
        bus.cnt1 = rc();
        if (!hold && $urandom_range(1) == 1) begin
          bus.req0 = 1'b0;
          bus.req1 = 1'b0;
        end
      end
      if (bus.enable_reading) begin
        if (en_n == 0) en_first = cyc;
        en_n++;
        if (mode != NEVER && en_n >= lat) bus.reading_done = 1'b1;
      end else if (mode == NORM) begin
        bus.reading_done = 1'b0;
      end
      nd0 += int'(bus.done0);
      nd1 += int'(bus.done1);
      ne0 += int'(bus.err0);
      ne1 += int'(bus.err1);
      if (bus.done0 || bus.done1 || bus.err0 || bus.err1) begin
        fin = cyc;
        fa = bus.ddr3_rd_start_addr;
        fc = bus.ddr3_rd_burst_cnt;
        fen = bus.enable_reading;
      end
    end
    chk("finish", 32'(fin >= 0), 1);
    if (fin < 0) begin
      do_reset();
      return;
    end
    if (!hold) begin
      bus.req0 = 1'b0;
      bus.req1 = 1'b0;
    end
    bus.reading_done = 1'b0;
    @(posedge clk);
    #1;
    chk("post_idle", outs(), 0);
    chk("owner", 32'(g_who), 32'(own));
    chk("addr", 32'(fa), 32'(ea));
    chk("cnt", 32'(fc), 32'(ec));
    chk("done", own ? nd1 : nd0, 32'(exp_done));
    chk("err", own ? ne1 : ne0, 32'(!exp_done));
    chk("other", own ? nd0 + ne0 : nd1 + ne1, 0);
    chk("excl", bad, 0);
    if (ec == '0) begin
      chk("zlen_en", en_n, 0);
      chk("zlen_lat", 32'((fin - g_cyc) inside {[1:2]}), 1);
    end else if (mode == NORM) begin
      chk("en_len", 32'(en_n inside {[lat + 1:lat + 3]}), 1);
    end else begin
      chk("to_lat",
          32'((fin - en_first) inside {[int'(TO) + 1:int'(TO) + 2]}), 1);
      chk("en_at_err", 32'(fen), 0);
    end
    last_own = own;
  endtask

  task automatic rtxn();
    int r, mode;
    logic [20:0] c0, c1;
    r  = $urandom_range(1, 3);
    c0 = ($urandom_range(5) == 0) ? 21'd0 : rc();
    c1 = ($urandom_range(5) == 0) ? 21'd0 : rc();
    if ($urandom_range(5) < 4) mode = NORM;
    else mode = ($urandom_range(1) == 1) ? NEVER : STUCK;
    txn(r[0], r[1], ra(), c0, ra(), c1, mode,
        $urandom_range(1, 40), 1'b0);
  endtask

  task automatic mid_reset();
    int n;
    bus.req0 = 1'b1;
    bus.addr0 = ra();
    bus.cnt0 = 21'd500;
    bus.req1 = 1'b0;
    bus.reading_done = 1'b0;
    n = 0;
    while (!bus.enable_reading && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("mid_run_en", 32'(bus.enable_reading), 1);
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("mid_rst_out", outs(), 0);
    reset = 1'b0;
    bus.req0 = 1'b0;
    last_own = 1'b1;
    @(posedge clk);
    #1;
    chk("mid_rst_idle", outs(), 0);
  endtask

  initial begin
    do_reset();
    for (int i = 0; i < 4; i++)
      txn(1'b1, 1'b1, ra(), rc(), ra(), rc(), NORM, 5 + i, i < 3);
    txn(1'b1, 1'b0, 23'h1234, 21'd100, ra(), rc(), NORM, 50, 1'b0);
    txn(1'b0, 1'b1, ra(), rc(), ra(), 21'd0, NORM, 10, 1'b0);
    txn(1'b1, 1'b0, ra(), 21'd77, ra(), rc(), NEVER, 1, 1'b0);
    txn(1'b0, 1'b1, ra(), rc(), ra(), 21'd9, STUCK, 12, 1'b0);
    for (int i = 0; i < 40; i++) rtxn();
    mid_reset();
    txn(1'b1, 1'b0, ra(), rc(), ra(), rc(), NORM, 8, 1'b0);
    txn(1'b1, 1'b1, ra(), rc(), ra(), rc(), NORM, 6, 1'b0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
